// File: rtl/seq_detect_prog_if.sv
// rtl/seq_detect_prog_if.sv - serial bit input and match outputs of the programmable sequence detector
interface seq_detect_prog_if #(
    parameter int CNT_W = 8
);
    logic             x_valid;
    logic             x;
    logic             z;
    logic             busy;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x_valid,
        output x,
        input  z,
        input  busy,
        input  match_cnt
    );

    modport slave (
        input  x_valid,
        input  x,
        output z,
        output busy,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - run-time programmable two-pattern serial sequence detector
module seq_detect_prog #(
    parameter int N     = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_detect_prog_if.slave s,
    input  logic             sel,
    input  logic [N-1:0]     pat_a,
    input  logic [LEN_W-1:0] len_a,
    input  logic [N-1:0]     pat_b,
    input  logic [LEN_W-1:0] len_b,
    input  logic             overlap,
    input  logic             cnt_clr
);
    localparam int FILL_W = $clog2(N + 1);
    localparam int CW     = (LEN_W > FILL_W) ? LEN_W : FILL_W;

    logic [N-1:0]      hist, hist_n, shifted, pat, mask;
    logic [FILL_W-1:0] fill, fill_n, fill_inc;
    logic              sel_q;
    logic              z_q, z_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [LEN_W-1:0]  len, l_eff;
    logic              match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            sel_q <= 1'b0;
            z_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            hist  <= hist_n;
            fill  <= fill_n;
            sel_q <= sel;
            z_q   <= z_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        pat      = sel ? pat_b : pat_a;
        len      = sel ? len_b : len_a;
        l_eff    = (len > LEN_W'(N)) ? LEN_W'(N) : len;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i < int'(l_eff));
        end
        shifted  = {hist[N-2:0], s.x};
        fill_inc = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);
        // A pattern switch restarts the stream, so the switching edge can never complete a match
        match    = s.x_valid && (sel == sel_q) && (l_eff >= LEN_W'(2))
                   && (((shifted ^ pat) & mask) == '0)
                   && (CW'(fill_inc) >= CW'(l_eff));

        hist_n = hist;
        fill_n = fill;
        z_n    = match;
        cnt_n  = cnt;
        if (s.x_valid) begin
            hist_n = shifted;
        end
        if (sel != sel_q) begin
            fill_n = s.x_valid ? FILL_W'(1) : '0;
        end else if (s.x_valid) begin
            fill_n = (match && !overlap) ? '0 : fill_inc;
        end
        if (cnt_clr) begin
            cnt_n = '0;
        end else if (match && (cnt != '1)) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        s.z         = z_q;
        s.match_cnt = cnt;
        s.busy      = (fill != '0);
    end
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed table-driven bench for seq_detect_prog
module tb_seq_detect_prog;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel, overlap, cnt_clr;
    logic [7:0] pat_a, pat_b;
    logic [3:0] len_a, len_b;
    logic       sel2, clr2;

    seq_detect_prog_if #(.CNT_W(8)) bus ();
    seq_detect_prog_if #(.CNT_W(2)) bus2 ();

    seq_detect_prog #(.N(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus.slave), .sel(sel),
        .pat_a(pat_a), .len_a(len_a), .pat_b(pat_b), .len_b(len_b),
        .overlap(overlap), .cnt_clr(cnt_clr)
    );

    seq_detect_prog #(.N(8), .LEN_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s(bus2.slave), .sel(sel2),
        .pat_a(8'b00001010), .len_a(4'd4), .pat_b(8'b00001010), .len_b(4'd4),
        .overlap(1'b1), .cnt_clr(clr2)
    );

    localparam logic [7:0] A6 = 8'b00110010;
    localparam logic [7:0] B6 = 8'b00110110;
    localparam logic [7:0] P4 = 8'b00001010;

    typedef struct {
        logic       sel;
        logic [7:0] pa;
        logic [3:0] la;
        logic       ovl;
        logic       xv;
        logic       x;
        logic       ez;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_seq(input logic s, input logic [7:0] pa, input logic [3:0] la,
                                    input logic o, input logic [15:0] bits, input int n,
                                    input logic [15:0] zs);
        vec_t v;
        for (int i = n - 1; i >= 0; i--) begin
            if (zs[i]) exp_cnt++;
            v.sel = s; v.pa = pa; v.la = la; v.ovl = o; v.xv = 1'b1;
            v.x = bits[i]; v.ez = zs[i]; v.ecnt = 8'(exp_cnt);
            tbl.push_back(v);
        end
    endfunction

    function automatic void add_idle(input logic s, input logic [7:0] pa, input logic [3:0] la,
                                     input logic o);
        vec_t v;
        v.sel = s; v.pa = pa; v.la = la; v.ovl = o; v.xv = 1'b0;
        v.x = 1'b0; v.ez = 1'b0; v.ecnt = 8'(exp_cnt);
        tbl.push_back(v);
    endfunction

    task automatic step(input logic s, input logic xv, input logic xb, input logic clr);
        @(negedge clk);
        sel = s; bus.x_valid = xv; bus.x = xb; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic xb, input logic clr);
        @(negedge clk);
        bus2.x_valid = 1'b1; bus2.x = xb; clr2 = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] s2_bits;
        logic [11:0] s2_z;
        int          s2_cnt [12];
        logic [5:0]  g_bits;
        logic [7:0]  tail;
        logic [4:0]  post;

        rst_n = 1'b0; sel = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;
        pat_a = A6; len_a = 4'd6; pat_b = B6; len_b = 4'd6;
        bus.x_valid = 1'b0; bus.x = 1'b0;
        sel2 = 1'b0; clr2 = 1'b0; bus2.x_valid = 1'b0; bus2.x = 1'b0;

        add_seq(0, A6, 6, 1, 16'b110010, 6, 16'b000001);
        add_seq(1, B6, 6, 0, 16'b110110, 6, 16'b000001);
        add_seq(1, B6, 6, 0, 16'b110010, 6, 16'b000000);
        add_seq(0, P4, 4, 1, 16'b1010101, 7, 16'b0001010);
        add_idle(1, P4, 4, 1);
        add_idle(0, P4, 4, 1);
        add_seq(0, P4, 4, 0, 16'b1010101, 7, 16'b0001000);
        add_idle(1, A6, 6, 1);
        add_idle(0, A6, 6, 1);
        g_bits = 6'b110010;
        for (int i = 5; i >= 0; i--) begin
            add_seq(0, A6, 6, 1, 16'(g_bits[i]), 1, 16'(i == 0));
            add_idle(0, A6, 6, 1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_z", bus.z, 0);
        check("reset_cnt", bus.match_cnt, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_cnt2", bus2.match_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            pat_a = tbl[k].pa; len_a = tbl[k].la; overlap = tbl[k].ovl;
            step(tbl[k].sel, tbl[k].xv, tbl[k].x, 1'b0);
            check($sformatf("tbl%0d_z", k), bus.z, tbl[k].ez);
            check($sformatf("tbl%0d_cnt", k), bus.match_cnt, tbl[k].ecnt);
        end

        // select toggle mid-stream discards the partial 1100 prefix
        pat_a = A6; len_a = 4'd6; overlap = 1'b1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tail = 8'b1100_0000;
        for (int i = 7; i >= 4; i--) begin
            step(0, 1, tail[i], 0);
            check("selchg_pre_z", bus.z, 0);
        end
        step(1, 0, 0, 0);
        check("selchg_busy", bus.busy, 0);
        step(0, 0, 0, 0);
        tail = 8'b10110010;
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, tail[i], 0);
            check($sformatf("selchg_z%0d", 7 - i), bus.z, (i == 0) ? 1 : 0);
        end
        check("selchg_cnt", bus.match_cnt, exp_cnt + 1);

        tail = 8'b1100_0000;
        for (int i = 7; i >= 4; i--) step(0, 1, tail[i], 0);
        check("pre_reset_busy", bus.busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_z", bus.z, 0);
        check("async_rst_cnt", bus.match_cnt, 0);
        check("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        post = 5'b10010;
        for (int i = 4; i >= 0; i--) begin
            step(0, 1, post[i], 0);
            check($sformatf("post_rst_z%0d", 4 - i), bus.z, 0);
        end
        bus.x_valid = 1'b0;

        s2_bits = 12'b1010_1010_1010;
        s2_z    = 12'b0001_0101_0101;
        s2_cnt  = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 0};
        for (int i = 11; i >= 0; i--) begin
            step2(s2_bits[i], (i == 0));
            check($sformatf("sat_z%0d", 11 - i), bus2.z, s2_z[i]);
            check($sformatf("sat_cnt%0d", 11 - i), bus2.match_cnt, s2_cnt[11 - i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
